// File: rtl/pmod_buttons.sv
// Debounced 8-button PMOD reader: 2-flop synchronizer, per-bit debounce counter,
// press/release pulses and a single-entry change snapshot with valid/ready handshake.
module pmod_buttons #(
   parameter int unsigned DEBOUNCE_CYCLES = 120000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire  [7:0] pmod,
   output logic [7:0] buttons,
   output logic [7:0] pressed,
   output logic [7:0] released,
   output logic       event_valid,
   output logic [7:0] event_data,
   output logic       event_overrun,
   input  logic       event_ready
);

   localparam int unsigned NB = 8;
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [NB-1:0] REL_LVL = ACTIVE_LOW ? {NB{1'b1}} : {NB{1'b0}};

   // Input-only connector: never driven.
   assign pmod = {NB{1'bz}};

   logic [NB-1:0]         sync1_q, sync2_q;
   logic [NB-1:0]         pin_p;
   logic [NB-1:0]         btn_q, btn_d;
   logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
   logic [NB-1:0]         pressed_q, pressed_d;
   logic [NB-1:0]         released_q, released_d;
   logic                  ev_valid_q, ev_valid_d;
   logic [NB-1:0]         ev_data_q, ev_data_d;
   logic                  ev_ovr_q, ev_ovr_d;
   logic                  change;

   assign pin_p = ACTIVE_LOW ? ~sync2_q : sync2_q;

   // Per-bit debounce: count consecutive mismatching cycles, toggle on the last one.
   always_comb begin
      btn_d = btn_q;
      cnt_d = cnt_q;
      for (int i = 0; i < NB; i++) begin
         if (pin_p[i] == btn_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == LAST) begin
            cnt_d[i] = '0;
            btn_d[i] = ~btn_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
      pressed_d  = btn_d & ~btn_q;
      released_d = ~btn_d & btn_q;
   end

   // Snapshot follows the pulses by one edge; a change always wins over a plain transfer.
   assign change = |(pressed_q | released_q);

   always_comb begin
      ev_valid_d = ev_valid_q;
      ev_data_d  = ev_data_q;
      ev_ovr_d   = ev_ovr_q;
      if (change) begin
         ev_valid_d = 1'b1;
         ev_data_d  = btn_q;
         ev_ovr_d   = ev_valid_q & ~event_ready;
      end else if (ev_valid_q && event_ready) begin
         ev_valid_d = 1'b0;
         ev_ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= REL_LVL;
         sync2_q    <= REL_LVL;
         btn_q      <= '0;
         cnt_q      <= '0;
         pressed_q  <= '0;
         released_q <= '0;
         ev_valid_q <= 1'b0;
         ev_data_q  <= '0;
         ev_ovr_q   <= 1'b0;
      end else begin
         sync1_q    <= pmod;
         sync2_q    <= sync1_q;
         btn_q      <= btn_d;
         cnt_q      <= cnt_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
         ev_valid_q <= ev_valid_d;
         ev_data_q  <= ev_data_d;
         ev_ovr_q   <= ev_ovr_d;
      end
   end

   assign buttons       = btn_q;
   assign pressed       = pressed_q;
   assign released      = released_q;
   assign event_valid   = ev_valid_q;
   assign event_data    = ev_data_q;
   assign event_overrun = ev_ovr_q;

endmodule

// File: tb/tb_pmod_buttons.sv
// Directed bench for pmod_buttons with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
module tb_pmod_buttons;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pmod_drv;
   wire  [7:0] pmod;
   logic [7:0] buttons, pressed, released, event_data;
   logic       event_valid, event_overrun, event_ready;
   int         checks = 0;
   int         failures = 0;

   assign pmod = pmod_drv;

   pmod_buttons #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .pmod(pmod), .buttons(buttons), .pressed(pressed),
      .released(released), .event_valid(event_valid), .event_data(event_data),
      .event_overrun(event_overrun), .event_ready(event_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".buttons"}, buttons, 8'h00);
      check({tag, ".pressed"}, pressed, 8'h00);
      check({tag, ".released"}, released, 8'h00);
      check({tag, ".valid"}, 8'(event_valid), 8'h00);
      check({tag, ".data"}, event_data, 8'h00);
      check({tag, ".overrun"}, 8'(event_overrun), 8'h00);
   endtask

   initial begin
      rst = 1'b1;
      pmod_drv = 8'hFF;
      event_ready = 1'b0;
      tick(2);
      check_all_zero("reset");
      rst = 1'b0;
      tick(3);
      check("idle.buttons", buttons, 8'h00);

      // Single press on bit 0: appears on the 6th edge, event one edge later.
      pmod_drv[0] = 1'b0;
      tick(5);
      check("p0.early", buttons, 8'h00);
      tick(1);
      check("p0.buttons", buttons, 8'h01);
      check("p0.pressed", pressed, 8'h01);
      check("p0.valid_early", 8'(event_valid), 8'h00);
      tick(1);
      check("p0.pressed_gone", pressed, 8'h00);
      check("p0.valid", 8'(event_valid), 8'h01);
      check("p0.data", event_data, 8'h01);
      check("p0.overrun", 8'(event_overrun), 8'h00);

      // Second press while the first snapshot is still pending.
      pmod_drv[1] = 1'b0;
      tick(6);
      check("p1.buttons", buttons, 8'h03);
      check("p1.pressed", pressed, 8'h02);
      check("p1.data_held", event_data, 8'h01);
      tick(1);
      check("ovr.valid", 8'(event_valid), 8'h01);
      check("ovr.data", event_data, 8'h03);
      check("ovr.overrun", 8'(event_overrun), 8'h01);
      event_ready = 1'b1;
      tick(1);
      check("acc.valid", 8'(event_valid), 8'h00);
      check("acc.overrun", 8'(event_overrun), 8'h00);
      // Ready with nothing pending changes nothing.
      tick(1);
      check("idle_rdy.valid", 8'(event_valid), 8'h00);
      check("idle_rdy.overrun", 8'(event_overrun), 8'h00);
      event_ready = 1'b0;

      // Two 3-cycle glitches on bit 3 separated by a 1-cycle gap.
      pmod_drv[3] = 1'b0; tick(3);
      pmod_drv[3] = 1'b1; tick(1);
      pmod_drv[3] = 1'b0; tick(3);
      pmod_drv[3] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         check("glitch.buttons", buttons, 8'h03);
         check("glitch.pulses", pressed | released, 8'h00);
         check("glitch.valid", 8'(event_valid), 8'h00);
      end

      // Reset with bits 0 and 1 held: full delay again after release.
      rst = 1'b1;
      tick(1);
      check("rst_hold.buttons", buttons, 8'h00);
      rst = 1'b0;
      tick(5);
      check("hold.early", buttons, 8'h00);
      tick(1);
      check("hold.buttons", buttons, 8'h03);
      check("hold.pressed", pressed, 8'h03);
      tick(1);
      check("hold.data", event_data, 8'h03);
      check("hold.valid", 8'(event_valid), 8'h01);

      // Release bit 0 while the pending 03 is accepted.
      pmod_drv[0] = 1'b1;
      tick(6);
      check("rel.buttons", buttons, 8'h02);
      check("rel.released", released, 8'h01);
      check("rel.pressed", pressed, 8'h00);
      event_ready = 1'b1;
      tick(1);
      event_ready = 1'b0;
      check("rel.valid", 8'(event_valid), 8'h01);
      check("rel.data", event_data, 8'h02);
      check("rel.overrun", 8'(event_overrun), 8'h00);
      check("rel.released_gone", released, 8'h00);
      tick(1);
      check("rel.valid_hold", 8'(event_valid), 8'h01);
      check("rel.data_hold", event_data, 8'h02);

      // All pressed; asynchronous reset mid-count.
      pmod_drv = 8'h00;
      tick(3);
      #3 rst = 1'b1;
      #1 check_all_zero("arst1");
      tick(1);
      rst = 1'b0;
      tick(5);
      check("all.early", buttons, 8'h00);
      tick(1);
      check("all.buttons", buttons, 8'hFF);
      check("all.pressed", pressed, 8'hFF);
      tick(1);
      check("all.data", event_data, 8'hFF);
      check("all.valid", 8'(event_valid), 8'h01);

      // Reset again with everything debounced and an event pending.
      #3 rst = 1'b1;
      #1 check_all_zero("arst2");
      rst = 1'b0;
      tick(5);
      check("all2.early", buttons, 8'h00);
      tick(1);
      check("all2.buttons", buttons, 8'hFF);
      check("all2.pressed", pressed, 8'hFF);
      tick(1);
      check("all2.pressed_gone", pressed, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pmod_buttons.md
PMOD_BUTTONS -- requirements
Module: pmod_buttons

Interface
REQ-001 The block SHALL provide parameter DEBOUNCE_CYCLES, default 120000, the number of consecutive clk cycles a pin must differ from the debounced state before that state changes (10 ms at 12 MHz).
REQ-002 The block SHALL provide parameter ACTIVE_LOW, default 1; when 1 a low pin level means pressed, when 0 a high pin level means pressed.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pmod  inout  8  PMOD connector pins; the block never drives them and holds all 8 at high-impedance.
REQ-006 buttons  output  8  debounced pressed state, 1 = pressed.
REQ-007 pressed  output  8  one-cycle pulse per bit on a debounced 0->1 transition.
REQ-008 released  output  8  one-cycle pulse per bit on a debounced 1->0 transition.
REQ-009 event_valid  output  1  a change snapshot is pending.
REQ-010 event_data  output  8  buttons value captured at the most recent change.
REQ-011 event_overrun  output  1  at least one change was overwritten before acceptance.
REQ-012 event_ready  input  1  consumer accepts the pending snapshot.

Function
REQ-013 Each pin SHALL pass through a 2-flop synchronizer, then be converted to pressed polarity per ACTIVE_LOW.
REQ-014 Each bit SHALL have an independent counter, width clog2(DEBOUNCE_CYCLES+1).
- synchronized bit equal to buttons bit: counter cleared to 0.
- unequal and counter < DEBOUNCE_CYCLES-1: counter increments.
- unequal and counter == DEBOUNCE_CYCLES-1: buttons bit toggles and counter clears.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave buttons unchanged and SHALL restart that bit's count from 0.
REQ-016 A clean pin change held steadily SHALL appear on buttons exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-017 pressed and released SHALL assert in the same cycle the buttons bit changes, for exactly one cycle; several bits may pulse together.
REQ-018 In any cycle where at least one buttons bit changes, event_data SHALL load the new buttons value on the following edge, and event_valid SHALL be 1.
REQ-019 Handshake: a transfer occurs when event_valid && event_ready; event_valid and event_data SHALL hold stable until the transfer.
REQ-020 A transfer with no simultaneous change SHALL clear event_valid and event_overrun on that edge.
REQ-021 A transfer with a simultaneous change SHALL load the new snapshot, keep event_valid at 1 and clear event_overrun.
REQ-022 A change while event_valid && !event_ready SHALL overwrite event_data with the newest value and set event_overrun.
REQ-023 event_ready while event_valid == 0 SHALL have no effect.
REQ-024 The block SHALL generate no combinational path from pmod or event_ready to any output.

Reset
REQ-025 Asserting rst SHALL immediately force:
- synchronizer flops to the released level,
- counters, buttons, pressed, released, event_valid, event_data and event_overrun to 0.
REQ-026 A button held pressed through reset release SHALL report a press only after the full DEBOUNCE_CYCLES+2 delay.
REQ-027 rst asserted mid-count SHALL discard the partial count; a pending event SHALL be lost.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
REQ-028 Drive pmod[0] low and hold -> buttons[0]=1 and pressed=8'h01 for one cycle, 6 edges after the first sampling edge; event_valid=1, event_data=8'h01 on the next edge.
REQ-029 Pulse pmod[3] low for 3 cycles, repeated twice with 1-cycle gaps -> buttons stays 8'h00 and no pulses or events.
REQ-030 Press bit 0 and hold event_ready=0, then press bit 1 -> event_data=8'h03 and event_overrun=1; assert event_ready one cycle -> event_valid=0, event_overrun=0.
REQ-031 Release bit 0 in the same cycle event_ready accepts the pending 8'h03 -> event_valid stays 1, event_data=8'h02, released=8'h01 for one cycle.
REQ-032 Hold pmod=8'h00, pulse rst mid-count and again after buttons=8'hFF -> all outputs 0 asynchronously; buttons returns to 8'hFF exactly 6 edges after rst deasserts; pressed=8'hFF for one cycle.
